// File: rtl/daq_dma_pkg.sv
// daq_dma_pkg: register map, status bit positions and FSM states
// shared by the DAQ DMA writer and its FIFO.
package daq_dma_pkg;

    localparam logic [1:0] REG_BASE = 2'd0;
    localparam logic [1:0] REG_SIZE = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_PTR  = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam int STAT_RUN      = 0;
    localparam int STAT_OVF      = 1;
    localparam int STAT_FULL     = 2;
    localparam int STAT_BUSY     = 3;
    localparam int STAT_LOST_LSB = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        FULL
    } state_t;

endpackage

// File: rtl/daq_dma_writer_if.sv
// daq_dma_writer_if: control slave, DAQ stream input and Avalon-MM
// master signals of the DAQ DMA writer; master = DMA side.
interface daq_dma_writer_if #(
    parameter int ADDR_W = 32
);
    logic [1:0]        avs_ctrl_address;
    logic              avs_ctrl_write;
    logic [31:0]       avs_ctrl_writedata;
    logic              avs_ctrl_read;
    logic [31:0]       avs_ctrl_readdata;
    logic              din_write;
    logic [15:0]       din_data;
    logic              running;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;

    modport master (
        input  avs_ctrl_address,
        input  avs_ctrl_write,
        input  avs_ctrl_writedata,
        input  avs_ctrl_read,
        output avs_ctrl_readdata,
        input  din_write,
        input  din_data,
        output running,
        output avm_address,
        output avm_write,
        output avm_writedata,
        output avm_byteenable,
        input  avm_waitrequest
    );

    modport slave (
        output avs_ctrl_address,
        output avs_ctrl_write,
        output avs_ctrl_writedata,
        output avs_ctrl_read,
        input  avs_ctrl_readdata,
        output din_write,
        output din_data,
        input  running,
        input  avm_address,
        input  avm_write,
        input  avm_writedata,
        input  avm_byteenable,
        output avm_waitrequest
    );

endinterface

// File: rtl/daq_dma_fifo.sv
// daq_dma_fifo: synchronous show-ahead 16-bit FIFO, depth 2**AW,
// with synchronous clear; pushes while full are discarded.
module daq_dma_fifo #(
    parameter int AW = 9
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_push,
    input  logic [15:0] i_data,
    input  logic        i_pop,
    output logic [15:0] o_data,
    output logic        o_full,
    output logic        o_empty
);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [15:0] r_mem [2**AW];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) &&
                     (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // fullness is judged before this cycle's pop
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n || i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + ONE;
            if (w_pop)  r_rptr <= r_rptr + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/daq_dma_writer.sv
// daq_dma_writer: DAQ stream consumer packing 16-bit words into 32-bit
// Avalon-MM writes. Define DAQ_DMA_LOSTCNT_EN for the lost-word counter.
module daq_dma_writer
    import daq_dma_pkg::*;
#(
    parameter int FIFO_AW = 9,
    parameter int ADDR_W  = 32
) (
    input logic              clk,
    input logic              reset_n,
    daq_dma_writer_if.master bus
);
    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_size;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [ADDR_W-1:0] w_wd_addr;
    logic              r_ovf;
    logic              r_full;
    logic [31:0]       r_rdata;
    logic [31:0]       w_status;
    logic [15:0]       w_lost;
    logic              r_half_vld;
    logic [15:0]       r_half;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_be;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [15:0]       w_fifo_data;
    logic              w_ctrl_wr;
    logic              w_start;
    logic              w_stop;
    logic              w_done;
    logic              w_hit_full;
    logic              w_push;
    logic              w_drop;
    logic              w_pop;
    logic              w_pad;
    logic              w_clr;
    logic              w_drained;

    assign w_wd_addr  = {bus.avs_ctrl_writedata[ADDR_W-1:2], 2'b00};
    assign w_ctrl_wr  = bus.avs_ctrl_write && (bus.avs_ctrl_address == REG_CTRL);
    assign w_start    = w_ctrl_wr && bus.avs_ctrl_writedata[CTRL_START] &&
                        (r_state == IDLE || r_state == FULL);
    assign w_stop     = w_ctrl_wr && !bus.avs_ctrl_writedata[CTRL_START] &&
                        (r_state == RUN);
    assign w_done     = r_wr && !bus.avm_waitrequest;
    assign w_ptr_inc  = r_ptr + ADDR_W'(4);
    assign w_hit_full = w_done && (w_ptr_inc == r_size);
    assign w_push     = bus.din_write && (r_state == RUN);
    assign w_drop     = w_push && w_fifo_full;
    // the second word of a pair may only leave the FIFO once the bus is free
    assign w_pop      = (r_state == RUN || r_state == FLUSH) && !w_fifo_empty &&
                        !(r_half_vld && r_wr);
    assign w_pad      = (r_state == FLUSH) && w_fifo_empty && r_half_vld && !r_wr;
    assign w_drained  = w_fifo_empty && !r_half_vld && !r_wr;
    assign w_clr      = w_start || w_hit_full;

    daq_dma_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  (bus.din_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, FULL: if (w_start) w_next = (r_size == '0) ? FULL : RUN;
            RUN: begin
                if (w_hit_full)  w_next = FULL;
                else if (w_stop) w_next = FLUSH;
            end
            FLUSH: begin
                if (w_hit_full)     w_next = FULL;
                else if (w_drained) w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_base <= '0;
            r_size <= '0;
            r_ptr  <= '0;
            r_full <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            if (bus.avs_ctrl_write && bus.avs_ctrl_address == REG_BASE) r_base <= w_wd_addr;
            if (bus.avs_ctrl_write && bus.avs_ctrl_address == REG_SIZE) r_size <= w_wd_addr;
            if (w_start) begin
                r_ptr  <= '0;
                r_full <= (r_size == '0);
            end else if (w_done) begin
                r_ptr <= w_ptr_inc;
                if (w_hit_full) r_full <= 1'b1;
            end
            if (w_drop) r_ovf <= 1'b1;
            else if (w_ctrl_wr && bus.avs_ctrl_writedata[CTRL_CLR_OVF]) r_ovf <= 1'b0;
        end
    end

`ifdef DAQ_DMA_LOSTCNT_EN
    logic [15:0] r_lost;

    always_ff @(posedge clk) begin
        if (!reset_n || w_start) r_lost <= '0;
        else if (w_drop && r_lost != 16'hFFFF) r_lost <= r_lost + 16'd1;
    end

    assign w_lost = r_lost;
`else
    assign w_lost = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_half_vld <= 1'b0;
            r_half     <= '0;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            if (w_done) r_wr <= 1'b0;
            if (w_clr) begin
                r_half_vld <= 1'b0;
            end else if (w_pop && r_half_vld) begin
                r_wr       <= 1'b1;
                r_addr     <= r_base + r_ptr;
                r_wdata    <= {w_fifo_data, r_half};
                r_be       <= 4'hF;
                r_half_vld <= 1'b0;
            end else if (w_pop) begin
                r_half     <= w_fifo_data;
                r_half_vld <= 1'b1;
            end else if (w_pad) begin
                r_wr       <= 1'b1;
                r_addr     <= r_base + r_ptr;
                r_wdata    <= {16'h0000, r_half};
                r_be       <= 4'h3;
                r_half_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        w_status                         = '0;
        w_status[STAT_RUN]               = (r_state == RUN);
        w_status[STAT_OVF]               = r_ovf;
        w_status[STAT_FULL]              = r_full;
        w_status[STAT_BUSY]              = (r_state != IDLE);
        w_status[STAT_LOST_LSB +: 16]    = w_lost;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdata <= '0;
        end else if (bus.avs_ctrl_read) begin
            unique case (bus.avs_ctrl_address)
                REG_BASE: r_rdata <= 32'(r_base);
                REG_SIZE: r_rdata <= 32'(r_size);
                REG_CTRL: r_rdata <= w_status;
                REG_PTR:  r_rdata <= 32'(r_ptr);
            endcase
        end
    end

    assign bus.avs_ctrl_readdata = r_rdata;
    assign bus.running           = (r_state == RUN);
    assign bus.avm_write         = r_wr;
    assign bus.avm_address       = r_addr;
    assign bus.avm_writedata     = r_wdata;
    assign bus.avm_byteenable    = r_be;

endmodule

// File: tb/tb_daq_dma_writer.sv
// tb_daq_dma_writer: directed vectors for daq_dma_writer with
// hand-computed register values and memory writes.
module tb_daq_dma_writer;
    import daq_dma_pkg::*;

    localparam int FIFO_AW = 9;
    localparam int ADDR_W  = 32;
`ifdef DAQ_DMA_LOSTCNT_EN
    localparam logic [31:0] LOST3 = 32'h0003_0000;
`else
    localparam logic [31:0] LOST3 = 32'h0000_0000;
`endif

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    logic [31:0] wq_a [$];
    logic [31:0] wq_d [$];
    logic [3:0]  wq_b [$];

    daq_dma_writer_if #(.ADDR_W(ADDR_W)) bus ();

    daq_dma_writer #(
        .FIFO_AW (FIFO_AW),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // memory side: record every completed write
    always @(negedge clk) begin
        if (bus.avm_write && !bus.avm_waitrequest) begin
            wq_a.push_back(bus.avm_address);
            wq_d.push_back(bus.avm_writedata);
            wq_b.push_back(bus.avm_byteenable);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        bus.avs_ctrl_address   = a;
        bus.avs_ctrl_writedata = d;
        bus.avs_ctrl_write     = 1'b1;
        step(1);
        bus.avs_ctrl_write     = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] a,
                          input logic [31:0] exp);
        bus.avs_ctrl_address = a;
        bus.avs_ctrl_read    = 1'b1;
        step(1);
        bus.avs_ctrl_read    = 1'b0;
        check(tag, bus.avs_ctrl_readdata, exp);
    endtask

    task automatic push(input logic [15:0] w);
        bus.din_write = 1'b1;
        bus.din_data  = w;
        step(1);
        bus.din_write = 1'b0;
    endtask

    task automatic wait_wr(input string tag, input int n, input int budget);
        int k = 0;
        while (wq_a.size() < n && k < budget) begin
            step(1);
            k++;
        end
        check(tag, wq_a.size(), n);
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        if (idx < wq_a.size()) begin
            check({tag, "_addr"}, wq_a[idx], a);
            check({tag, "_data"}, wq_d[idx], d);
            check({tag, "_be"}, {28'h0, wq_b[idx]}, {28'h0, be});
        end else begin
            check({tag, "_present"}, wq_a.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        bus.avs_ctrl_address   = 2'd0;
        bus.avs_ctrl_write     = 1'b0;
        bus.avs_ctrl_writedata = 32'h0;
        bus.avs_ctrl_read      = 1'b0;
        bus.din_write          = 1'b0;
        bus.din_data           = 16'h0;
        bus.avm_waitrequest    = 1'b0;

        step(3);
        check("rst_avm_write", {31'h0, bus.avm_write}, 32'h0);
        check("rst_running", {31'h0, bus.running}, 32'h0);
        reset_n = 1'b1;
        step(1);
        for (int r = 0; r < 4; r++) rd_chk("rst_reg", 2'(r), 32'h0);

        // basic fill: four pair writes until the buffer is full
        reg_wr(REG_BASE, 32'h0000_1003);
        reg_wr(REG_SIZE, 32'h0000_0010);
        rd_chk("t1_base", REG_BASE, 32'h0000_1000);
        reg_wr(REG_CTRL, 32'h1);
        rd_chk("t1_stat_run", REG_CTRL, 32'h9);
        for (int i = 1; i <= 8; i++) push(16'(i));
        wait_wr("t1_wr_count", 4, 100);
        step(5);
        check("t1_wr_total", wq_a.size(), 4);
        chk_wr("t1_w0", 0, 32'h1000, 32'h0002_0001, 4'hF);
        chk_wr("t1_w1", 1, 32'h1004, 32'h0004_0003, 4'hF);
        chk_wr("t1_w2", 2, 32'h1008, 32'h0006_0005, 4'hF);
        chk_wr("t1_w3", 3, 32'h100C, 32'h0008_0007, 4'hF);
        check("t1_running", {31'h0, bus.running}, 32'h0);
        rd_chk("t1_stat_full", REG_CTRL, 32'hC);
        rd_chk("t1_ptr", REG_PTR, 32'h10);

        // long stall: the writer holds one word in its packer and two in the
        // stalled request, so three extra pushes beyond those overflow
        base = wq_a.size();
        bus.avm_waitrequest = 1'b1;
        reg_wr(REG_BASE, 32'h0000_2000);
        reg_wr(REG_SIZE, 32'h0001_0000);
        reg_wr(REG_CTRL, 32'h1);
        for (int i = 0; i < (2**FIFO_AW) + 6; i++) push(16'h0100 + 16'(i));
        check("t2_stall_write", {31'h0, bus.avm_write}, 32'h1);
        check("t2_stall_addr", bus.avm_address, 32'h2000);
        check("t2_stall_data", bus.avm_writedata, 32'h0101_0100);
        rd_chk("t2_stat_ovf", REG_CTRL, 32'hB | LOST3);
        step(650);
        check("t2_hold_write", {31'h0, bus.avm_write}, 32'h1);
        check("t2_hold_addr", bus.avm_address, 32'h2000);
        check("t2_hold_data", bus.avm_writedata, 32'h0101_0100);
        check("t2_hold_be", {28'h0, bus.avm_byteenable}, 32'hF);
        check("t2_no_complete", wq_a.size(), base);

        // stop + overflow clear; lost count stays until the next start
        reg_wr(REG_CTRL, 32'h2);
        rd_chk("t6_ovf_clr", REG_CTRL, 32'h8 | LOST3);
        check("t6_still_stalled", {31'h0, bus.avm_write}, 32'h1);

        // reset in the middle of a stalled write
        reset_n = 1'b0;
        step(1);
        check("t4_avm_write", {31'h0, bus.avm_write}, 32'h0);
        check("t4_running", {31'h0, bus.running}, 32'h0);
        step(1);
        reset_n = 1'b1;
        bus.avm_waitrequest = 1'b0;
        step(1);
        for (int r = 0; r < 4; r++) rd_chk("t4_reg", 2'(r), 32'h0);
        check("t4_no_complete", wq_a.size(), base);

        // stop with an odd word left: padded half-word write
        reg_wr(REG_BASE, 32'h0000_3000);
        reg_wr(REG_SIZE, 32'h0000_0100);
        reg_wr(REG_CTRL, 32'h1);
        rd_chk("t3_stat_run", REG_CTRL, 32'h9);
        push(16'h0001);
        push(16'h0002);
        push(16'h0003);
        step(4);
        reg_wr(REG_CTRL, 32'h0);
        wait_wr("t3_wr_count", base + 2, 50);
        step(3);
        chk_wr("t3_w0", base, 32'h3000, 32'h0002_0001, 4'hF);
        chk_wr("t3_w1", base + 1, 32'h3004, 32'h0000_0003, 4'h3);
        rd_chk("t3_ptr", REG_PTR, 32'h8);
        rd_chk("t3_stat_idle", REG_CTRL, 32'h0);

        // stream while idle is ignored; size 0 start goes straight to full
        base = wq_a.size();
        for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i));
        step(10);
        check("t5_idle_no_wr", wq_a.size(), base);
        rd_chk("t5_idle_stat", REG_CTRL, 32'h0);
        reg_wr(REG_SIZE, 32'h0);
        reg_wr(REG_CTRL, 32'h1);
        step(5);
        check("t5_zero_no_wr", wq_a.size(), base);
        check("t5_zero_avm", {31'h0, bus.avm_write}, 32'h0);
        rd_chk("t5_zero_stat", REG_CTRL, 32'hC);
        rd_chk("t5_zero_ptr", REG_PTR, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
